// File: rtl/fpcvt_pkg.sv
// Shared types for the fpcvt scheduler: fp8 result layout and FSM states.
// The FPCVT_SAT_EN macro (see fpcvt_sched) does not affect this package.
package fpcvt_pkg;

  localparam int FP_IN_W = 12;
  localparam int FP_E_W  = 3;
  localparam int FP_F_W  = 4;

  typedef struct packed {
    logic              s;
    logic [FP_E_W-1:0] e;
    logic [FP_F_W-1:0] f;
  } fp8_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fpcvt_core.sv
// Combinational 12-bit two's-complement to sign/3-bit exponent/4-bit fraction converter.
// FPCVT_SAT_EN adds the sat output flagging a clamped (unroundable) result.
module fpcvt_core
  import fpcvt_pkg::*;
(
  input  logic signed [FP_IN_W-1:0] din,
  output fp8_t                      dout
`ifdef FPCVT_SAT_EN
  ,
  output logic                      sat
`endif
);

  logic [FP_IN_W-1:0] mag;
  logic [FP_IN_W-1:0] shifted;
  logic [3:0]         lz;
  logic [FP_E_W-1:0]  e_raw;
  logic [FP_E_W+FP_F_W-1:0] ef_rnd;
  logic               min_neg;

  // Round-half-up on the first dropped bit; a fraction carry renormalises
  // into the exponent unless the exponent is already at its top code.
  function automatic logic [FP_E_W+FP_F_W-1:0] round_ef(
    input logic [FP_E_W-1:0] e,
    input logic [FP_F_W-1:0] f,
    input logic              r
  );
    if (!r)
      return {e, f};
    else if (f != 4'hF)
      return {e, f + 4'd1};
    else if (e != 3'd7)
      return {e + 3'd1, 4'b1000};
    else
      return {e, f};
  endfunction

`ifdef FPCVT_SAT_EN
  function automatic logic sat_hit(
    input logic [FP_E_W-1:0] e,
    input logic [FP_F_W-1:0] f,
    input logic              r
  );
    return r && (f == 4'hF) && (e == 3'd7);
  endfunction
`endif

  always_comb begin
    mag     = din[FP_IN_W-1] ? $unsigned(-din) : $unsigned(din);
    shifted = mag;
    lz      = 4'd0;
    // Normalise: at most 8 shifts, so tiny magnitudes end up denormal-like with E=0.
    for (int i = 0; i < 8; i++) begin
      if (!shifted[FP_IN_W-1]) begin
        shifted = shifted << 1;
        lz      = lz + 4'd1;
      end
    end
    e_raw   = (lz == 4'd0) ? 3'd7 : 3'(4'd8 - lz);
    ef_rnd  = round_ef(e_raw, shifted[11:8], shifted[7]);
    // -2048 has no positive magnitude in 12 bits; clamp it to the largest code.
    min_neg = din[FP_IN_W-1] && (din[FP_IN_W-2:0] == '0);
    dout.s  = din[FP_IN_W-1];
    dout.e  = min_neg ? 3'd7  : ef_rnd[FP_E_W+FP_F_W-1:FP_F_W];
    dout.f  = min_neg ? 4'hF : ef_rnd[FP_F_W-1:0];
  end

`ifdef FPCVT_SAT_EN
  assign sat = min_neg | sat_hit(e_raw, shifted[11:8], shifted[7]);
`endif

endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one fpcvt_core among NREQ sample requesters.
// Define FPCVT_SAT_EN to add the registered out_sat port.
module fpcvt_sched
  import fpcvt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*FP_IN_W-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDW-1:0]          out_id,
  output logic                    out_s,
  output logic [FP_E_W-1:0]       out_e,
  output logic [FP_F_W-1:0]       out_f,
  output logic                    busy
`ifdef FPCVT_SAT_EN
  ,
  output logic                    out_sat
`endif
);

  sched_state_t             state;
  logic [IDW-1:0]           rr_ptr;
  logic [IDW-1:0]           ptr_nxt;
  logic [IDW-1:0]           gnt_idx;
  logic                     gnt_any;
  int                       idx;
  logic signed [FP_IN_W-1:0] samp_p0;
  logic [IDW-1:0]           id_p0;
  fp8_t                     conv_p1;
`ifdef FPCVT_SAT_EN
  logic                     sat_p1;
`endif

  // Arbitration: first valid at or after rr_ptr, only while idle and out of reset.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    req_ready = '0;
    if (rst_n && (state == IDLE)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = IDW'(idx);
        end
      end
    end
    if (gnt_any)
      req_ready[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = IDW'((int'(gnt_idx) + 1) % NREQ);
  assign busy    = (state != IDLE);

  // Stage p0: captured sample and its requester index.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      samp_p0 <= $signed(req_data[int'(gnt_idx)*FP_IN_W +: FP_IN_W]);
      id_p0   <= gnt_idx;
    end
  end

  fpcvt_core u_core (
    .din  (samp_p0),
    .dout (conv_p1)
`ifdef FPCVT_SAT_EN
    ,
    .sat  (sat_p1)
`endif
  );

  // Stage p1: converted result registered onto the output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
`ifdef FPCVT_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            rr_ptr <= ptr_nxt;
            state  <= CONV;
          end
        end
        CONV: begin
          out_valid <= 1'b1;
          out_id    <= id_p0;
          out_s     <= conv_p1.s;
          out_e     <= conv_p1.e;
          out_f     <= conv_p1.f;
`ifdef FPCVT_SAT_EN
          out_sat   <= sat_p1;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_sched.sv
// Scoreboard bench for fpcvt_sched: randomized requesters, arithmetic reference model.
// Honours FPCVT_SAT_EN for the out_sat port.
module tb_fpcvt_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef FPCVT_SAT_EN
  localparam int SATV = 1;
`else
  localparam int SATV = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*12-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_id;
  logic              out_s;
  logic [2:0]        out_e;
  logic [3:0]        out_f;
  logic              busy;
  logic              out_sat;

  fpcvt_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .busy      (busy)
`ifdef FPCVT_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

`ifndef FPCVT_SAT_EN
  assign out_sat = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] pend;
  logic [11:0]     pdata [NREQ];
  int              mptr, inflight, acc_cyc, n_out, last_pk;
  int              gcount [NREQ];
  int              grant_log [$];
  int              sb [$];
  bit              refill;

  function automatic void chk(string nm, int act, int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endfunction

  function automatic int pk(int id, int s, int e, int f, int sat);
    return (id << 9) | (s << 8) | (e << 5) | (f << 1) | sat;
  endfunction

  // Reference: exponent from the position of the magnitude's leading one.
  function automatic int ref_conv(int id, logic [11:0] d);
    int v, mag, p, s, e, f, r, sat;
    v = int'(d);
    if (v >= 2048) v = v - 4096;
    s = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    e = 0; f = 0; r = 0; sat = 0;
    if (v == -2048) begin
      e = 7; f = 15; sat = 1;
    end else if (mag != 0) begin
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      if (p < 3) begin
        f = mag;
      end else begin
        e = (p >= 10) ? 7 : p - 3;
        f = (mag >> (p - 3)) & 15;
        if (p >= 4) r = (mag >> (p - 4)) & 1;
      end
      if (r != 0) begin
        if (f != 15) f++;
        else if (e < 7) begin f = 8; e++; end
        else sat = 1;
      end
    end
    if (SATV == 0) sat = 0;
    return pk(id, s, e, f, sat);
  endfunction

  function automatic logic [11:0] rnd_sample();
    int c;
    c = $urandom_range(0, 7);
    if (c == 0) return 12'h800;
    if (c == 1) return 12'h7FF;
    if (c == 2) return 12'($urandom_range(0, 31));
    if (c == 3) return 12'(4096 - $urandom_range(1, 31));
    return 12'($urandom);
  endfunction

  task automatic step(input bit ord);
    int  pred, j;
    bit  took;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_data[i*12 +: 12] = pdata[i];
    req_valid = pend;
    out_ready = ord;
    #1;
    if (inflight == 0 && pend != 0) begin
      pred = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (pred < 0 && pend[j]) pred = j;
      end
      chk("grant", int'(req_ready), 1 << pred);
    end else begin
      chk("no_grant", int'(req_ready), 0);
    end
    took = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!took && req_valid[i] && req_ready[i]) begin
        took = 1'b1;
        sb.push_back(ref_conv(i, pdata[i]));
        inflight++;
        acc_cyc = cyc;
        mptr = (i + 1) % NREQ;
        grant_log.push_back(i);
        gcount[i]++;
        pend[i] = 1'b0;
        if (refill) begin
          pend[i]  = 1'b1;
          pdata[i] = rnd_sample();
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend != 0 || inflight != 0) && n < 300) begin
      step(1'b1);
      n++;
    end
    chk("drain_done", (pend != 0 || inflight != 0) ? 1 : 0, 0);
  endtask

  task automatic run_one(input int id, input logic [11:0] d);
    pend[id]  = 1'b1;
    pdata[id] = d;
    drain();
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  bit pv, pr;
  int ppk, cur, expv;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      cur = pk(int'(out_id), int'(out_s), int'(out_e), int'(out_f), int'(out_sat));
      if (out_valid) begin
        chk("ready_in_resp", int'(req_ready), 0);
        chk("busy_in_resp", int'(busy), 1);
        if (pv && !pr) chk("hold_stable", cur, ppk);
        if (!pv) chk("latency", cyc - acc_cyc, 2);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", cur, -1);
        end else begin
          expv = sb.pop_front();
          chk("result", cur, expv);
        end
        inflight--;
        n_out++;
        last_pk = cur;
      end
      pv  = out_valid;
      pr  = out_ready;
      ppk = cur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, g0, n, start;
    rst_n = 1'b0;
    req_valid = '1;
    req_data = '0;
    out_ready = 1'b0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin pdata[i] = '0; gcount[i] = 0; end
    mptr = 0; inflight = 0; acc_cyc = 0; n_out = 0; last_pk = 0; refill = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_out_sef", pk(0, int'(out_s), int'(out_e), int'(out_f), int'(out_sat)), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed conversions.
    g0 = gcount[2];
    run_one(2, 12'h1A6);
    chk("req2_pulses", gcount[2] - g0, 1);
    chk("d_1A6", last_pk, pk(2, 0, 5, 13, 0));
    run_one(0, 12'h07D);
    chk("d_07D", last_pk, pk(0, 0, 4, 8, 0));
    run_one(0, 12'h000);
    chk("d_000", last_pk, pk(0, 0, 0, 0, 0));
    run_one(1, 12'h7FF);
    chk("d_7FF", last_pk, pk(1, 0, 7, 15, SATV));
    run_one(3, 12'h800);
    chk("d_800", last_pk, pk(3, 1, 7, 15, SATV));

    // Backpressure: hold RESP for 10 cycles with another requester waiting.
    pend[1] = 1'b1; pdata[1] = rnd_sample();
    pend[3] = 1'b1; pdata[3] = rnd_sample();
    n = 0;
    while (!out_valid && n < 20) begin step(1'b0); n++; end
    chk("bp_valid_seen", int'(out_valid), 1);
    repeat (10) step(1'b0);
    chk("bp_still_valid", int'(out_valid), 1);
    n0 = n_out;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("bp_one_handshake", n_out - n0, 1);
    drain();

    // Reset during CONV drops the sample.
    pend[1] = 1'b1; pdata[1] = rnd_sample();
    n = 0;
    while (inflight == 0 && n < 20) begin step(1'b1); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    pend = '0;
    sb.delete();
    inflight = 0;
    mptr = 0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_out;
    repeat (6) step(1'b1);
    chk("rst_mid_dropped", n_out - n0, 0);

    // All requesters held valid: order must be 0,1,2,3,0 from reset pointer.
    start = grant_log.size();
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; pdata[i] = rnd_sample(); end
    n = 0;
    while ((grant_log.size() - start) < 5 && n < 60) begin step(1'b1); n++; end
    refill = 1'b0;
    for (int k = 0; k < 5; k++)
      chk("rr_order", (start + k < grant_log.size()) ? grant_log[start + k] : -1, k % NREQ);
    drain();
    chk("rr_no_loss", sb.size(), 0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = rnd_sample();
        end
      end
      step($urandom_range(0, 3) != 0);
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpcvt_sched.md
# fpcvt_sched

Round-robin scheduler that shares one 12-bit two's-complement to 8-bit floating-point converter among NREQ requesters. Each requester presents a sample with a valid/ready handshake. The scheduler grants one requester at a time and registers the sample into the shared conversion stage. It returns the sign/exponent/fraction result, tagged with the requester index, on a single valid/ready output port. It sits between the sample producers and the float consumer.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester index
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester sample valid
- req_data  in  NREQ*12  per-requester sample; requester i at bits [12i+11:12i]
- req_ready  out  NREQ  one-hot grant/accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_id  out  IDW  index of requester that produced the result
- out_s  out  1  sign
- out_e  out  3  exponent
- out_f  out  4  fraction
- out_sat  out  1  saturation flag (only with FPCVT_SAT_EN)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - Pick the first asserted req_valid at or after rr_ptr, wrapping modulo NREQ.
  - Assert that req_ready bit combinationally.
  - On the handshake, capture the data and the index, set rr_ptr to (grant+1) mod NREQ, and go to CONV.
  - With no valid, stay in IDLE and leave rr_ptr unchanged.
- CONV: the captured sample passes through the combinational converter. The result registers into out_s/e/f/sat, then go to RESP.
- RESP:
  - out_valid is high; outputs are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - req_ready is all-zero in CONV and RESP.
- Conversion rules (converter sub-module):
  - S = D[11].
  - mag = S ? -D : D, 12-bit.
  - Shift mag left while mag[11]==0, up to 8 shifts; lz = shift count.
  - E = (lz==0) ? 7 : 8-lz.
  - F = shifted[11:8]; rounding bit R = shifted[7].
  - If R: when F!=1111, F = F+1. When F==1111 and E<7, set F=1000 and E=E+1. When F==1111 and E==7, F stays 1111 (saturate).
  - D == -2048 (0x800) overrides to E=7, F=1111.
- Requesters hold valid and data stable until accepted. A deasserted valid is never granted.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, out_valid=0, out_id=0, out_s=0, out_e=0, out_f=0, out_sat=0, busy=0.
- Accept at edge t, out_valid high from t+2.
- Minimum occupancy is 3 cycles per conversion: accept, CONV, RESP with out_ready already high. A new accept is possible on the cycle after the out handshake.
- Backpressure: out_ready low holds RESP indefinitely, with no limit. All requesters stall (req_ready=0).
- Simultaneous valids: strict round-robin from rr_ptr. No requester waits more than NREQ grants.
- Reset asserted mid-transaction: the in-flight sample is dropped and no output is produced. All registers return to their reset values asynchronously.

## Configuration
- FPCVT_SAT_EN defined:
  - out_sat port exists.
  - It is high when rounding is suppressed by the E==7, F==1111 case, or when D == -2048.
  - It is registered with the other outputs.
- FPCVT_SAT_EN undefined: out_sat port and its logic are absent. Other behaviour is identical.

## Structure
- Shared package fpcvt_pkg holds:
  - FP_IN_W=12, FP_E_W=3, FP_F_W=4.
  - Typedef fp8_t {s, e, f}.
  - FSM enum sched_state_t {IDLE, CONV, RESP}.
- Sub-module fpcvt_core: purely combinational converter (12-bit in → fp8_t plus sat). Instantiated once.
- Arbitration, FSM and output registers live in fpcvt_sched.

## Test plan
- Reset then a single request on requester 2 with D=0x1A6 (422):
  - One req_ready pulse on bit 2.
  - Two cycles later out_valid with out_id=2, S=0, E=5, F=1101.
- Requester 0 with D=0x07D (125): E=4, F=1000 (round-carry renormalise). With D=0x000: E=0, F=0000.
- D=0x7FF (2047): S=0, E=7, F=1111, out_sat=1. D=0x800 (-2048): S=1, E=7, F=1111, out_sat=1.
- All four valids held high:
  - Grants occur in order 0,1,2,3,0.
  - Each out_id matches its request, and no request is lost.
- out_ready low for 10 cycles in RESP: outputs stable, req_ready stays 0. Release gives exactly one handshake.
- rst_n pulsed low during CONV: out_valid never rises for that sample, and rr_ptr returns to 0.
